adc_seq_ctrl: RTL
=================

Name: adc_seq_ctrl

Overview:
- Parametrised N-channel parallel-ADC acquisition sequencer; generalises the existing three-channel converter controller.
- A start request triggers FRAMES conversion rounds. Each round pulses conversion-start on every ADC, waits for all busy flags to release, then reads each channel over a shared data bus and writes it to sample RAM at an auto-incrementing address.
- Sits between the ADC pins and the sample RAM write port.
- Adds configurable channel count, frame count, conversion pulse width, busy blanking, a done/busy status and an optional busy timeout.

Parameters:
- N_CH, 3, number of ADC channels (2..8).
- DATA_W, 8, ADC data width.
- ADDR_W, 11, sample RAM address width.
- FRAMES, 4, conversion rounds per start (>=1).
- CONV_CYC, 2, nconvst low width in clocks (>=1).
- BLANK_CYC, 2, clocks after nconvst rises during which nbusy is ignored.
- TIMEOUT_CYC, 1024, busy timeout in clocks (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- start  in  1  level; a 0->1 transition (registered edge detect) requests a run.
- nbusy  in  N_CH  per-ADC busy, active-low.
- indata  in  DATA_W  shared ADC data bus.
- nconvst  out  N_CH  per-ADC conversion start, active-low.
- enout_n  out  N_CH  per-ADC output enable, active-low, one-hot-or-none.
- wr  out  1  RAM write strobe, active-high, one clock.
- address  out  ADDR_W  RAM write address.
- outdata  out  DATA_W  RAM write data.
- run  out  1  high while not IDLE.
- done  out  1  one-clock pulse when the final write of a run completes.
- err  out  1  sticky busy-timeout flag.

Behaviour:
- Reset (synchronous, active-high, overrides any state):
  - nconvst and enout_n all 1s; wr=0; address=0; outdata=0; run=0; done=0; err=0.
  - state=IDLE; channel/frame counters=0; start edge register cleared.
  - Reset mid-run abandons the run; no partial write follows.
- States: IDLE, CONV, BLANK, WAIT, RD, LATCH, WRITE.
  - IDLE: a start edge moves to CONV next clock. start edges in any other state are ignored (not queued).
  - CONV: nconvst=all 0 for exactly CONV_CYC clocks, then BLANK.
  - BLANK: nconvst=all 1; hold BLANK_CYC clocks, then WAIT.
  - WAIT: leave when nbusy is all 1s (registered sample), to RD with ch=0. No upper bound unless TIMEOUT_EN.
  - RD: enout_n[ch]=0 for one clock.
  - LATCH: enout_n[ch] stays 0; outdata<=indata at the end of the clock.
  - WRITE: enout_n all 1; wr=1 for one clock with the current address/outdata. address increments by 1 after the write and wraps modulo 2^ADDR_W with no stall or flag.
    - If ch<N_CH-1: ch++, go to RD.
    - Else if frame<FRAMES-1: frame++, go to CONV.
    - Else: done=1 next clock, go to IDLE.
- Per-channel cost: 3 clocks. Per-frame cost: CONV_CYC+BLANK_CYC+wait+3*N_CH.
- address is not cleared between runs; each run appends. Only reset clears it.
- run=1 from the clock after the start edge through the WRITE clock of the last sample.
- Simultaneous start edge and done pulse: the edge is ignored.

Optional Feature:
- Macro ADC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT; reaching TIMEOUT_CYC sets err=1 (sticky until reset) and forces RD.
  - The frame's samples are still read and written as normal.
- Undefined: WAIT waits indefinitely and err is tied to 0.

Decomposition:
- Package adc_seq_pkg: state enum, ENOUT_IDLE/NCONV_IDLE all-ones constants, and a clog2-based counter-width function.
- One natural sub-module, adc_seq_timer: a loadable down-counter with a zero flag. It is reused for CONV_CYC, BLANK_CYC and TIMEOUT_CYC.

Test Plan:
- Basic run: defaults; reset high 4 clocks; start pulse; ADC models drop nbusy for 10 clocks and return 0x10*ch+frame. Required: 12 wr pulses at addresses 0..11 with data 0x00,0x10,0x20,0x01,...,0x23; done is one pulse; run falls with it.
- Timing: check nconvst low for exactly 2 clocks; nbusy low during BLANK has no effect; enout_n is one-hot for exactly 2 clocks before each wr.
- Append and wrap: ADDR_W=4, two consecutive runs. Required: second run writes addresses 12..15 then 0..7.
- Ignored start: start edge during WAIT of frame 1. Required: still exactly 12 writes and one done.
- Reset mid-run: reset asserted in LATCH of channel 1, frame 2. Required: next clock all outputs at reset values; no wr until a new start.
- Timeout (ADC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16): nbusy[2] stuck low. Required: err rises 16 clocks into WAIT; writes continue; err stays 1 after done.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and helpers for the ADC acquisition sequencer.
//   state_t     : sequencer state encoding
//   ENOUT_IDLE  : all-ones idle level for the active-low output enables (up to MAX_CH)
//   NCONV_IDLE  : all-ones idle level for the active-low conversion starts (up to MAX_CH)
//   cnt_w()     : bits needed to hold a counter value 0..maxval (minimum 1)
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        BLANK,
        WAIT,
        RD,
        LATCH,
        WRITE
    } state_t;

    localparam int unsigned MAX_CH = 8;

    localparam logic [MAX_CH-1:0] ENOUT_IDLE = '1;
    localparam logic [MAX_CH-1:0] NCONV_IDLE = '1;

    function automatic int unsigned cnt_w(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: loadable down-counter with a zero flag, shared by the
// conversion-pulse, blanking and busy-timeout intervals.
//   clk      in  : system clock
//   reset    in  : synchronous active-high reset (count -> 0)
//   load     in  : load load_val this clock (has priority over counting)
//   load_val in  : value to load
//   zero     out : count is zero; the counter holds at zero
module adc_seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: N-channel parallel-ADC acquisition sequencer.
// A start edge runs FRAMES rounds: pulse nconvst on all ADCs, blank, wait for
// all busy flags to release, then read each channel over the shared bus and
// write it to sample RAM at an auto-incrementing (wrapping) address.
//   CLK      in  : system clock
//   reset    in  : synchronous active-high reset
//   start    in  : level; registered 0->1 edge requests a run (IDLE only)
//   nbusy    in  : per-ADC busy, active-low
//   indata   in  : shared ADC data bus
//   nconvst  out : per-ADC conversion start, active-low
//   enout_n  out : per-ADC output enable, active-low, one-hot-or-none
//   wr       out : RAM write strobe, one clock
//   address  out : RAM write address, appends across runs, cleared by reset only
//   outdata  out : RAM write data
//   run      out : high while a run is in progress
//   done     out : one-clock pulse after the final write of a run
//   err      out : sticky busy-timeout flag
// Optional feature: define ADC_SEQ_TIMEOUT_EN to bound WAIT by TIMEOUT_CYC
// clocks (sets err, forces the read); otherwise err stays 0.
// CONV_CYC and BLANK_CYC must be >= 1.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned FRAMES      = 4,
    parameter int unsigned CONV_CYC    = 2,
    parameter int unsigned BLANK_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [N_CH-1:0]   nbusy,
    input  logic [DATA_W-1:0] indata,
    output logic [N_CH-1:0]   nconvst,
    output logic [N_CH-1:0]   enout_n,
    output logic              wr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] outdata,
    output logic              run,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMR_MAX =
        (CONV_CYC > BLANK_CYC) ? ((CONV_CYC > TIMEOUT_CYC) ? CONV_CYC : TIMEOUT_CYC)
                               : ((BLANK_CYC > TIMEOUT_CYC) ? BLANK_CYC : TIMEOUT_CYC);
    localparam int unsigned TMR_W = cnt_w(TMR_MAX);
    localparam int unsigned CH_W  = cnt_w(N_CH - 1);
    localparam int unsigned FR_W  = cnt_w(FRAMES - 1);

    // Loads are interval-1 because the timer is checked for zero on the last clock
    localparam logic [TMR_W-1:0] CONV_LD  = TMR_W'(CONV_CYC - 1);
    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LD   = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAMES - 1);
    localparam logic [N_CH-1:0] CH0_SEL = N_CH'(1);

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [FR_W-1:0]   frame;
    logic              start_q;
    logic [N_CH-1:0]   nbusy_q;
    logic              start_edge;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    adc_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (CLK),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Timer is loaded on the same clock the FSM enters the timed state
    always_comb begin
        start_edge = start & ~start_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (start_edge && !done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CONV_LD;
                end
            end
            CONV: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LD;
                end
            end
            BLANK: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LD;
                end
            end
            WRITE: begin
                if (ch == CH_LAST && frame != FR_LAST) begin
                    tmr_load = 1'b1;
                    tmr_val  = CONV_LD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            ch      <= '0;
            frame   <= '0;
            start_q <= 1'b0;
            nbusy_q <= '1;
            nconvst <= NCONV_IDLE[N_CH-1:0];
            enout_n <= ENOUT_IDLE[N_CH-1:0];
            wr      <= 1'b0;
            address <= '0;
            outdata <= '0;
            run     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            start_q <= start;
            nbusy_q <= nbusy;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    // An edge coinciding with the done pulse is dropped
                    if (start_edge && !done) begin
                        state   <= CONV;
                        run     <= 1'b1;
                        nconvst <= '0;
                    end
                end
                CONV: begin
                    if (tmr_zero) begin
                        nconvst <= NCONV_IDLE[N_CH-1:0];
                        state   <= BLANK;
                    end
                end
                BLANK: begin
                    if (tmr_zero) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (&nbusy_q) begin
                        ch      <= '0;
                        enout_n <= ~CH0_SEL;
                        state   <= RD;
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (tmr_zero) begin
                        err     <= 1'b1;
                        ch      <= '0;
                        enout_n <= ~CH0_SEL;
                        state   <= RD;
                    end
`endif
                end
                RD: begin
                    state <= LATCH;
                end
                LATCH: begin
                    outdata <= indata;
                    enout_n <= ENOUT_IDLE[N_CH-1:0];
                    wr      <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    wr      <= 1'b0;
                    address <= address + 1'b1;
                    if (ch != CH_LAST) begin
                        ch      <= ch + 1'b1;
                        enout_n <= ~(CH0_SEL << (ch + 1'b1));
                        state   <= RD;
                    end else if (frame != FR_LAST) begin
                        frame   <= frame + 1'b1;
                        ch      <= '0;
                        nconvst <= '0;
                        state   <= CONV;
                    end else begin
                        frame <= '0;
                        ch    <= '0;
                        run   <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
